// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC and computes PC+4 and the jump target.
// It fetches the word at PC over a req/ack instruction-memory port and latches it into IR.
// The fetch sequencer has four states: IDLE, REQ, WAIT and DONE.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [31:0] NextAddr,
    input  logic        FetchStart,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] JumpAddr,
    output logic [31:0] IR,
    output logic        IRValid,
    output logic        Busy,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last WAIT count value before a missing ack is declared a timeout
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        irvalid_q, irvalid_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    // Set when PC was reloaded on the same edge that launched the fetch,
    // so the returning word belongs to the old PC and must not be marked valid
    logic        stale_q, stale_d;
    logic        start_fetch;

    // A fetch launches only from IDLE and only while no error is latched
    assign start_fetch = (state_q == S_IDLE) && FetchStart && !err_q;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_fetch) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next-values for the current state
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        irvalid_d = irvalid_q;
        req_d     = req_q;
        addr_d    = addr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        stale_d   = stale_q;
        Busy      = (state_q == S_REQ) || (state_q == S_WAIT);

        // A misaligned target is still loaded so software can inspect it
        if ((state_q == S_IDLE) && PCWre) begin
            pc_d      = NextAddr;
            irvalid_d = 1'b0;
            if (NextAddr[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // The request carries the PC as it was before any same-edge load
                if (start_fetch) begin
                    addr_d    = pc_q;
                    req_d     = 1'b1;
                    irvalid_d = 1'b0;
                    stale_d   = PCWre;
                end
            end
            S_REQ: begin
                cnt_d = 8'd0;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ir_d      = imem_rdata;
                    irvalid_d = !stale_q;
                    req_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        req_d = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            irvalid_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= 32'd0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            stale_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            irvalid_q <= irvalid_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            stale_q   <= stale_d;
        end
    end

    assign PC        = pc_q;
    assign PCPlus4   = pc_q + 32'd4;
    assign JumpAddr  = {PCPlus4[31:28], ir_q[25:0], 2'b00};
    assign IR        = ir_q;
    assign IRValid   = irvalid_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign FetchErr  = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit. Each fetch pushes the expected {IRValid, IR} onto a queue.
// The entry is popped and compared when the DUT completes that fetch.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic [31:0] NextAddr;
    logic        FetchStart;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] JumpAddr;
    logic [31:0] IR;
    logic        IRValid;
    logic        Busy;
    logic        FetchErr;

    int checks;
    int failures;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .NextAddr(NextAddr),
        .FetchStart(FetchStart), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC), .PCPlus4(PCPlus4),
        .JumpAddr(JumpAddr), .IR(IR), .IRValid(IRValid), .Busy(Busy), .FetchErr(FetchErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; PCWre = 0; NextAddr = 0; FetchStart = 0; imem_ack = 0; imem_rdata = 0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        checks++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=%h", PCPlus4, 32'h4); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (IRValid !== 1'b0) begin failures++; $display("FAIL reset_irvalid got=%b exp=0", IRValid); end
        checks++; if (FetchErr !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", FetchErr); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (IR !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", IR); end
    endtask

    task automatic test_fetch_basic();
        PCWre = 1; NextAddr = 32'h0000_0040;
        tick();
        PCWre = 0;
        checks++; if (PC !== 32'h40) begin failures++; $display("FAIL basic_pc got=%h exp=%h", PC, 32'h40); end
        FetchStart = 1;
        tick();
        FetchStart = 0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL basic_addr got=%h exp=%h", imem_addr, 32'h40); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", Busy); end
        exp_q.push_back({1'b1, 32'h0800_0010});
        tick();
        checks++; if (IRValid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", IRValid); end
        imem_ack = 1; imem_rdata = 32'h0800_0010;
        tick();
        imem_ack = 0;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL basic_sb_empty got=none exp=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (IR !== e[31:0]) begin failures++; $display("FAIL basic_ir got=%h exp=%h", IR, e[31:0]); end
            checks++; if (IRValid !== e[32]) begin failures++; $display("FAIL basic_irvalid got=%b exp=%b", IRValid, e[32]); end
        end
        checks++; if (JumpAddr !== 32'h0000_0040) begin failures++; $display("FAIL basic_jump got=%h exp=%h", JumpAddr, 32'h40); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", imem_req); end
        FetchStart = 1;
        tick();
        FetchStart = 0;
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL done_start_ignored got=%b exp=0", imem_req); end
    endtask

    task automatic test_delayed_ack();
        FetchStart = 1;
        tick();
        FetchStart = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin PCWre = 1; NextAddr = 32'h0000_0080; end
            tick();
            PCWre = 0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                failures++; $display("FAIL delay_hold req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 32'h40);
            end
        end
        imem_ack = 1; imem_rdata = 32'h2000_00AA;
        exp_q.push_back({1'b1, 32'h2000_00AA});
        tick();
        imem_ack = 0;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL delay_sb_empty got=none exp=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (IR !== e[31:0]) begin failures++; $display("FAIL delay_ir got=%h exp=%h", IR, e[31:0]); end
            checks++; if (IRValid !== e[32]) begin failures++; $display("FAIL delay_irvalid got=%b exp=%b", IRValid, e[32]); end
        end
        checks++; if (PC !== 32'h40) begin failures++; $display("FAIL delay_pc got=%h exp=%h", PC, 32'h40); end
        tick();
    endtask

    task automatic test_timeout();
        FetchStart = 1;
        tick();
        FetchStart = 0;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL to_hold_%0d got=%b exp=1", i, imem_req); end
        end
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_req got=%b exp=0", imem_req); end
        checks++; if (FetchErr !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", FetchErr); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", Busy); end
        checks++; if (IR !== 32'h2000_00AA) begin failures++; $display("FAIL to_ir got=%h exp=%h", IR, 32'h2000_00AA); end
        checks++; if (IRValid !== 1'b0) begin failures++; $display("FAIL to_irvalid got=%b exp=0", IRValid); end
        FetchStart = 1;
        tick(); tick();
        FetchStart = 0;
        checks++; if (imem_req !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL to_start_blocked req=%b busy=%b exp 0 0", imem_req, Busy); end
    endtask

    task automatic test_misalign();
        do_reset();
        PCWre = 1; NextAddr = 32'h0000_0042;
        tick();
        PCWre = 0;
        checks++; if (PC !== 32'h42) begin failures++; $display("FAIL mis_pc got=%h exp=%h", PC, 32'h42); end
        checks++; if (FetchErr !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", FetchErr); end
        PCWre = 1; NextAddr = 32'hFFFF_FFFC;
        tick();
        PCWre = 0;
        checks++; if (PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'hFFFF_FFFC); end
        checks++; if (PCPlus4 !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4 got=%h exp=0", PCPlus4); end
        FetchStart = 1;
        tick();
        FetchStart = 0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_start_blocked got=%b exp=0", imem_req); end
    endtask

    task automatic test_same_edge();
        do_reset();
        PCWre = 1; NextAddr = 32'h0000_0100; FetchStart = 1;
        tick();
        PCWre = 0; FetchStart = 0;
        checks++; if (PC !== 32'h100) begin failures++; $display("FAIL same_pc got=%h exp=%h", PC, 32'h100); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL same_addr got=%h exp=0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL same_req got=%b exp=1", imem_req); end
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        tick();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL same_sb_empty got=none exp=entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (IR !== e[31:0]) begin failures++; $display("FAIL same_ir got=%h exp=%h", IR, e[31:0]); end
            checks++; if (IRValid !== e[32]) begin failures++; $display("FAIL same_irvalid got=%b exp=%b", IRValid, e[32]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        FetchStart = 1;
        tick();
        FetchStart = 0;
        tick(); tick();
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", imem_req); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
        #2;
        Reset = 1'b1;
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick(); tick();
        imem_ack = 0;
        checks++; if (IRValid !== 1'b0) begin failures++; $display("FAIL rstmid_irvalid got=%b exp=0", IRValid); end
        checks++; if (IR !== 32'h0) begin failures++; $display("FAIL rstmid_ir got=%h exp=0", IR); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_after got=%b exp=0", imem_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc_m;
        logic [31:0] word;
        int unsigned dly;
        pc_m = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            PCWre = 1; NextAddr = pc_m;
            tick();
            PCWre = 0;
            FetchStart = 1;
            tick();
            FetchStart = 0;
            checks++; if (imem_addr !== pc_m) begin failures++; $display("FAIL b2b_addr_%0d got=%h exp=%h", k, imem_addr, pc_m); end
            tick();
            dly = $urandom_range(0, 3);
            repeat (dly) tick();
            word = $urandom;
            imem_ack = 1; imem_rdata = word;
            exp_q.push_back({1'b1, word});
            tick();
            imem_ack = 0;
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_sb_empty_%0d got=none exp=entry", k); end
            else begin
                e = exp_q.pop_front();
                checks++; if (IR !== e[31:0]) begin failures++; $display("FAIL b2b_ir_%0d got=%h exp=%h", k, IR, e[31:0]); end
                checks++; if (IRValid !== e[32]) begin failures++; $display("FAIL b2b_irvalid_%0d got=%b exp=%b", k, IRValid, e[32]); end
            end
            tick();
            pc_m = pc_m + 32'd4;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fetch_basic();
        test_delayed_ack();
        test_timeout();
        test_misalign();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
